// File: rtl/multicycle_control_unit.sv
// Multicycle control FSM for the 16-bit datapath: sequences fetch/decode/execute/memory/writeback
// and drives ALUcomp's Op plus every datapath select and write enable.
module multicycle_control_unit #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [3:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic [3:0]       alu_op,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       pc_source,
    output logic             pc_write,
    output logic             ir_write,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic             reg_dst,
    output logic [1:0]       mem_to_reg,
    output logic             instr_done,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] retired_count
);

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StExec    = 4'd2,
        StAluWb   = 4'd3,
        StMemAddr = 4'd4,
        StMemRd   = 4'd5,
        StMemWb   = 4'd6,
        StMemWr   = 4'd7,
        StBranch  = 4'd8,
        StJump    = 4'd9,
        StJal     = 4'd10,
        StJr      = 4'd11
    } state_e;

    localparam logic [3:0] OpAddi = 4'h1;
    localparam logic [3:0] OpBeq  = 4'h3;
    localparam logic [3:0] OpBne  = 4'h4;
    localparam logic [3:0] OpJ    = 4'h5;
    localparam logic [3:0] OpJal  = 4'h6;
    localparam logic [3:0] OpJr   = 4'h7;
    localparam logic [3:0] OpLw   = 4'h8;
    localparam logic [3:0] OpSw   = 4'hF;
    localparam logic [3:0] AluSub = 4'hE;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] retired_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StFetch;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (instr_done) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StFetch: begin
                if (mem_ready) begin
                    state_d = StDecode;
                end
            end
            StDecode: begin
                case (opcode)
                    OpLw, OpSw:   state_d = StMemAddr;
                    OpBeq, OpBne: state_d = StBranch;
                    OpJ:          state_d = StJump;
                    OpJal:        state_d = StJal;
                    OpJr:         state_d = StJr;
                    default:      state_d = StExec;
                endcase
            end
            StExec:    state_d = StAluWb;
            StMemAddr: state_d = (opcode == OpLw) ? StMemRd : StMemWr;
            StMemRd: begin
                if (mem_ready) begin
                    state_d = StMemWb;
                end
            end
            StMemWr: begin
                if (mem_ready) begin
                    state_d = StFetch;
                end
            end
            StAluWb, StMemWb, StBranch, StJump, StJal, StJr: state_d = StFetch;
            default: state_d = StFetch;
        endcase
    end

    always_comb begin
        alu_op     = 4'b0000;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_source  = 2'b00;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 2'b00;
        instr_done = 1'b0;

        case (state_q)
            StFetch: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            StDecode: begin
                // Speculatively form the branch target into ALUOut.
                alu_src_b = 2'b11;
            end
            StExec: begin
                alu_src_a = 1'b1;
                alu_op    = opcode;
                alu_src_b = (opcode == OpAddi) ? 2'b10 : 2'b00;
            end
            StAluWb: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            StMemAddr: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            StMemRd: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            StMemWb: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'b01;
                instr_done = 1'b1;
            end
            StMemWr: begin
                mem_write  = 1'b1;
                iord       = 1'b1;
                instr_done = mem_ready;
            end
            StBranch: begin
                alu_src_a  = 1'b1;
                alu_op     = AluSub;
                pc_source  = 2'b01;
                instr_done = 1'b1;
                pc_write   = ((opcode == OpBeq) & zero) | ((opcode == OpBne) & ~zero);
            end
            StJump: begin
                pc_write   = 1'b1;
                pc_source  = 2'b10;
                instr_done = 1'b1;
            end
            StJal: begin
                pc_write   = 1'b1;
                pc_source  = 2'b10;
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                mem_to_reg = 2'b10;
                instr_done = 1'b1;
            end
            StJr: begin
                pc_write   = 1'b1;
                pc_source  = 2'b11;
                instr_done = 1'b1;
            end
            default: ;
        endcase

        // Reset abandons any in-flight instruction: no side effects, no retirement.
        if (reset) begin
            pc_write   = 1'b0;
            ir_write   = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            reg_write  = 1'b0;
            instr_done = 1'b0;
        end
    end

    assign state         = state_q;
    assign retired_count = retired_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized bench for multicycle_control_unit: per-instruction cycle plans are built from the
// latency rules, and every cycle's outputs are checked against a per-state output table.
module tb_multicycle_control_unit;

    localparam int S_FETCH = 0, S_DECODE = 1, S_EXEC = 2, S_ALU_WB = 3, S_MEM_ADDR = 4;
    localparam int S_MEM_RD = 5, S_MEM_WB = 6, S_MEM_WR = 7, S_BRANCH = 8, S_JUMP = 9;
    localparam int S_JAL = 10, S_JR = 11;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] opcode = 4'h0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;

    logic [3:0]  alu_op, st;
    logic        alu_src_a, pc_write, ir_write, iord, mem_read, mem_write, reg_write, reg_dst;
    logic        instr_done;
    logic [1:0]  alu_src_b, pc_source, mem_to_reg;
    logic [15:0] cnt16;

    logic [3:0]  s_alu_op, s_st;
    logic        s_alu_src_a, s_pc_write, s_ir_write, s_iord, s_mem_read, s_mem_write;
    logic        s_reg_write, s_reg_dst, s_instr_done;
    logic [1:0]  s_alu_src_b, s_pc_source, s_mem_to_reg;
    logic [1:0]  cnt2;

    int          n_assert = 0;
    int          n_fail = 0;
    int unsigned retired = 0;

    multicycle_control_unit #(.CNT_W(16)) dut (
        .clock(clock), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source),
        .pc_write(pc_write), .ir_write(ir_write), .iord(iord), .mem_read(mem_read),
        .mem_write(mem_write), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .instr_done(instr_done), .state(st), .retired_count(cnt16)
    );

    multicycle_control_unit #(.CNT_W(2)) dut_small (
        .clock(clock), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .alu_op(s_alu_op), .alu_src_a(s_alu_src_a), .alu_src_b(s_alu_src_b),
        .pc_source(s_pc_source), .pc_write(s_pc_write), .ir_write(s_ir_write), .iord(s_iord),
        .mem_read(s_mem_read), .mem_write(s_mem_write), .reg_write(s_reg_write),
        .reg_dst(s_reg_dst), .mem_to_reg(s_mem_to_reg), .instr_done(s_instr_done),
        .state(s_st), .retired_count(cnt2)
    );

    always #5 clock = ~clock;

    logic [18:0] ctrl, s_ctrl;
    assign ctrl = {alu_op, alu_src_a, alu_src_b, pc_source, pc_write, ir_write, iord, mem_read,
                   mem_write, reg_write, reg_dst, mem_to_reg, instr_done};
    assign s_ctrl = {s_alu_op, s_alu_src_a, s_alu_src_b, s_pc_source, s_pc_write, s_ir_write,
                     s_iord, s_mem_read, s_mem_write, s_reg_write, s_reg_dst, s_mem_to_reg,
                     s_instr_done};

    // Expected control word for a state, straight from the per-state output rules.
    function automatic logic [18:0] expect_ctrl(input int s, input logic [3:0] op,
                                                input logic z, input logic mr, input logic rst);
        logic [3:0] aop;
        logic       sa, pw, irw, io, mrd, mwr, rw, rd, dn;
        logic [1:0] sb, ps, m2r;
        aop = 4'h0; sa = 0; sb = 2'b00; ps = 2'b00; m2r = 2'b00;
        pw = 0; irw = 0; io = 0; mrd = 0; mwr = 0; rw = 0; rd = 0; dn = 0;
        case (s)
            S_FETCH:    begin mrd = 1; sb = 2'b01; irw = mr; pw = mr; end
            S_DECODE:   sb = 2'b11;
            S_EXEC:     begin sa = 1; aop = op; sb = (op == 4'h1) ? 2'b10 : 2'b00; end
            S_ALU_WB:   begin rw = 1; dn = 1; end
            S_MEM_ADDR: begin sa = 1; sb = 2'b10; end
            S_MEM_RD:   begin mrd = 1; io = 1; end
            S_MEM_WB:   begin rw = 1; m2r = 2'b01; dn = 1; end
            S_MEM_WR:   begin mwr = 1; io = 1; dn = mr; end
            S_BRANCH: begin
                sa = 1; aop = 4'b1110; ps = 2'b01; dn = 1;
                pw = (op == 4'h3 && z) || (op == 4'h4 && !z);
            end
            S_JUMP:     begin pw = 1; ps = 2'b10; dn = 1; end
            S_JAL:      begin pw = 1; ps = 2'b10; rw = 1; rd = 1; m2r = 2'b10; dn = 1; end
            S_JR:       begin pw = 1; ps = 2'b11; dn = 1; end
            default: ;
        endcase
        if (rst) begin
            pw = 0; irw = 0; mrd = 0; mwr = 0; rw = 0; dn = 0;
        end
        return {aop, sa, sb, ps, pw, irw, io, mrd, mwr, rw, rd, m2r, dn};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: inputs already set, check outputs mid-cycle, then counters after the edge.
    task automatic cycle(input int exp_st, input logic mr);
        logic [18:0] e;
        logic [31:0] r;
        mem_ready = mr;
        @(negedge clock);
        e = expect_ctrl(exp_st, opcode, zero, mr, reset);
        check("state", 32'(st), 32'(exp_st));
        check("ctrl", 32'(ctrl), 32'(e));
        check("state_small", 32'(s_st), 32'(exp_st));
        check("ctrl_small", 32'(s_ctrl), 32'(e));
        if (reset) retired = 0;
        else if (e[0]) retired++;
        @(posedge clock);
        #1;
        r = retired;
        check("retired16", 32'(cnt16), r & 32'hFFFF);
        check("retired2", 32'(cnt2), r % 4);
    endtask

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Build and run one instruction's cycle plan from the latency rules.
    task automatic run_instr(input logic [3:0] op, input logic z, input int fst, input int mst);
        opcode = op;
        zero = z;
        for (int i = 0; i < fst; i++) cycle(S_FETCH, 1'b0);
        cycle(S_FETCH, 1'b1);
        cycle(S_DECODE, rnd_bit());
        case (op)
            4'h8: begin
                cycle(S_MEM_ADDR, rnd_bit());
                for (int i = 0; i < mst; i++) cycle(S_MEM_RD, 1'b0);
                cycle(S_MEM_RD, 1'b1);
                cycle(S_MEM_WB, rnd_bit());
            end
            4'hF: begin
                cycle(S_MEM_ADDR, rnd_bit());
                for (int i = 0; i < mst; i++) cycle(S_MEM_WR, 1'b0);
                cycle(S_MEM_WR, 1'b1);
            end
            4'h3, 4'h4: cycle(S_BRANCH, rnd_bit());
            4'h5:       cycle(S_JUMP, rnd_bit());
            4'h6:       cycle(S_JAL, rnd_bit());
            4'h7:       cycle(S_JR, rnd_bit());
            default: begin
                cycle(S_EXEC, rnd_bit());
                cycle(S_ALU_WB, rnd_bit());
            end
        endcase
    endtask

    initial begin
        reset = 1'b1;
        @(posedge clock);
        #1;
        cycle(S_FETCH, 1'b1);
        cycle(S_FETCH, 1'b0);
        reset = 1'b0;

        run_instr(4'h0, 1'b0, 0, 0);
        run_instr(4'h8, 1'b0, 2, 1);
        run_instr(4'h3, 1'b1, 0, 0);
        run_instr(4'h3, 1'b0, 0, 0);
        run_instr(4'h4, 1'b1, 0, 0);
        run_instr(4'h4, 1'b0, 0, 0);
        run_instr(4'h6, 1'b0, 0, 0);
        run_instr(4'h1, 1'b0, 1, 0);
        run_instr(4'hF, 1'b0, 0, 2);
        for (int i = 0; i < 5; i++) run_instr(4'h7, rnd_bit(), 0, 0);

        for (int i = 0; i < 60; i++) begin
            run_instr(4'($urandom_range(0, 15)), rnd_bit(), int'($urandom_range(0, 2)),
                      int'($urandom_range(0, 2)));
        end

        // sw stalled in MEM_WR, then reset lands mid-write.
        opcode = 4'hF;
        zero = 1'b0;
        cycle(S_FETCH, 1'b1);
        cycle(S_DECODE, 1'b1);
        cycle(S_MEM_ADDR, 1'b1);
        cycle(S_MEM_WR, 1'b0);
        reset = 1'b1;
        cycle(S_MEM_WR, 1'b1);
        reset = 1'b0;
        run_instr(4'h0, 1'b0, 0, 0);
        run_instr(4'h7, 1'b0, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multicycle control FSM for the 16-bit datapath, directly upstream of ALUcomp.
- Decodes the 4-bit instruction opcode and sequences fetch, decode, execute, memory and writeback.
- Drives ALUcomp's Op input (alu_op) and all datapath mux selects and write enables.
- Handshakes with memory through mem_ready and counts retired instructions.

Parameters:
CNT_W, 16, width of retired_count.

Ports:
clock  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
opcode  in  4  IR[15:12]; 0 add,1 addi,2 and,3 beq,4 bne,5 j,6 jal,7 jr,8 lw,9 or,A slt,B sll,C srl,D sra,E sub,F sw
zero  in  1  ALU result == 0
mem_ready  in  1  memory completes current read/write this cycle
alu_op  out  4  to ALUcomp Op
alu_src_a  out  1  0=PC, 1=regA
alu_src_b  out  2  00=regB, 01=const 2, 10=sign-ext imm, 11=sign-ext imm<<1
pc_source  out  2  00=ALU result, 01=ALUOut, 10=jump target, 11=regA
pc_write  out  1  PC load enable
ir_write  out  1  IR load enable
iord  out  1  memory address: 0=PC, 1=ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
reg_write  out  1  register file write enable
reg_dst  out  1  1=link register (jal)
mem_to_reg  out  2  00=ALUOut, 01=MDR, 10=PC
instr_done  out  1  one-cycle pulse in last cycle of each instruction
state  out  4  current state encoding (debug)
retired_count  out  CNT_W  instructions retired, wraps modulo 2^CNT_W

Behaviour:
- State encodings:
  - 0 FETCH, 1 DECODE, 2 EXEC, 3 ALU_WB, 4 MEM_ADDR, 5 MEM_RD, 6 MEM_WB, 7 MEM_WR
  - 8 BRANCH, 9 JUMP, 10 JAL, 11 JR
- Output defaults in every state: all enables 0, alu_op=0000, selects 0. Each state below lists only deviations.
- Outputs are combinational from state, opcode, zero and mem_ready.
- While reset=1, all enables are forced 0 regardless of state.
- Reset: state<=FETCH, retired_count<=0 on the first rising edge with reset=1.
  - Reset mid-instruction abandons the instruction: no writes and no instr_done.
- FETCH:
  - Outputs: mem_read=1, alu_src_b=01, alu_op=0000.
  - While mem_ready=1: ir_write=1, pc_write=1 (pc_source=00), then go to DECODE.
  - While mem_ready=0: hold in FETCH; ir_write and pc_write stay 0.
- DECODE:
  - Outputs: alu_src_b=11, alu_op=0000 (branch target into ALUOut).
  - Next state by opcode:
    - add/and/or/slt/sll/srl/sra/sub/addi -> EXEC
    - lw/sw -> MEM_ADDR
    - beq/bne -> BRANCH
    - j -> JUMP, jal -> JAL, jr -> JR
- EXEC:
  - Outputs: alu_src_a=1, alu_op=opcode.
  - alu_src_b=10 for addi, 00 otherwise.
  - Next: ALU_WB.
- ALU_WB: reg_write=1, mem_to_reg=00, instr_done=1; next FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=0000; next MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: mem_read=1, iord=1; hold until mem_ready=1, then MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=01, instr_done=1; next FETCH.
- MEM_WR: mem_write=1, iord=1, held until mem_ready=1. That cycle asserts instr_done=1; next FETCH.
- BRANCH:
  - Outputs: alu_src_a=1, alu_src_b=00, alu_op=1110, pc_source=01, instr_done=1.
  - pc_write = (opcode==3 & zero) | (opcode==4 & ~zero).
  - Next: FETCH.
- JUMP: pc_write=1, pc_source=10, instr_done=1; next FETCH.
- JAL: pc_write=1, pc_source=10, reg_write=1, reg_dst=1, mem_to_reg=10, instr_done=1; next FETCH.
- JR: pc_write=1, pc_source=11, instr_done=1; next FETCH.
- Opcode is sampled combinationally each cycle; IR is stable after FETCH, so opcode must not change DECODE..end.
- Latency with mem_ready held 1:
  - R-type/addi 4 cycles; lw 5; sw 4; beq/bne/j/jal/jr 3.
  - Each mem_ready=0 cycle in FETCH, MEM_RD or MEM_WR adds exactly one cycle.
- retired_count increments on each clock edge where instr_done=1 and reset=0; wraps from 2^CNT_W-1 to 0.
- reset=1 and instr_done in the same cycle: reset wins; no increment.

Test Plan:
- Reset then add (opcode 0), mem_ready=1 -> state 0,1,2,3,0; alu_op 0000,0000,0000,–; reg_write only in state 3; instr_done pulses once; retired_count=1.
- lw (8) with mem_ready low 2 cycles in FETCH and 1 in MEM_RD -> 8 cycles total; ir_write/pc_write only on ready FETCH cycle; mem_to_reg=01 in state 6.
- beq (3) zero=1 -> pc_write=1, pc_source=01, alu_op=1110 in state 8; zero=0 -> pc_write=0. bne (4) inverse.
- jal (6) -> 3 cycles; state 10 asserts pc_write, reg_write, reg_dst=1, mem_to_reg=10, pc_source=10.
- sw (F) with mem_ready=0; assert reset during MEM_WR -> mem_write drops same cycle; next state 0; retired_count unchanged, no instr_done.
- CNT_W=2, run 5 jr (7) instructions -> retired_count 1,2,3,0,1; each instruction 3 cycles with pc_source=11.
